// File: rtl/perceptron_wload.sv
// rtl/perceptron_wload.sv - parallel weight/bias set to MSB-first serial loader for the perceptron datapath
module perceptron_wload #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid_i,
    output logic             load_ready_o,
    input  logic [WIDTH-1:0] b_par_i,
    input  logic [WIDTH-1:0] w0_par_i,
    input  logic [WIDTH-1:0] w1_par_i,
    input  logic             abort_i,
    output logic [1:0]       W1W0b_en_o,
    output logic             b_o,
    output logic             W0_o,
    output logic             W1_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             weights_loaded_o
);

    localparam int            CW     = $clog2(WIDTH);
    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SH_B,
        ST_SH_W0,
        ST_SH_W1,
        ST_DONE
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_b_hold;
    logic [WIDTH-1:0] r_w0_hold;
    logic [WIDTH-1:0] r_w1_hold;
    logic [1:0]       r_en;
    logic             r_b;
    logic             r_w0;
    logic             r_w1;
    logic             r_busy;
    logic             r_done;
    logic             r_loaded;
    logic             r_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_b_hold  <= '0;
            r_w0_hold <= '0;
            r_w1_hold <= '0;
            r_en      <= 2'b00;
            r_b       <= 1'b0;
            r_w0      <= 1'b0;
            r_w1      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_loaded  <= 1'b0;
            r_ready   <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_en    <= 2'b00;
                    r_b     <= 1'b0;
                    r_w0    <= 1'b0;
                    r_w1    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                    if (load_valid_i && r_ready) begin
                        r_b_hold  <= b_par_i;
                        r_w0_hold <= w0_par_i;
                        r_w1_hold <= w1_par_i;
                        r_cnt     <= C_LAST;
                        r_state   <= ST_SH_B;
                        r_ready   <= 1'b0;
                        r_loaded  <= 1'b0;
                    end
                end

                ST_SH_B, ST_SH_W0, ST_SH_W1: begin
                    // Abort leaves the datapath partially loaded, so no done and no loaded flag.
                    if (abort_i) begin
                        r_state <= ST_IDLE;
                        r_en    <= 2'b00;
                        r_b     <= 1'b0;
                        r_w0    <= 1'b0;
                        r_w1    <= 1'b0;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                    end else begin
                        r_busy <= 1'b1;
                        r_b    <= (r_state == ST_SH_B)  & r_b_hold[r_cnt];
                        r_w0   <= (r_state == ST_SH_W0) & r_w0_hold[r_cnt];
                        r_w1   <= (r_state == ST_SH_W1) & r_w1_hold[r_cnt];
                        case (r_state)
                            ST_SH_B:  r_en <= 2'b01;
                            ST_SH_W0: r_en <= 2'b10;
                            default:  r_en <= 2'b11;
                        endcase
                        if (r_cnt == '0) begin
                            r_cnt <= C_LAST;
                            case (r_state)
                                ST_SH_B:  r_state <= ST_SH_W0;
                                ST_SH_W0: r_state <= ST_SH_W1;
                                default:  r_state <= ST_DONE;
                            endcase
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    r_en     <= 2'b00;
                    r_b      <= 1'b0;
                    r_w0     <= 1'b0;
                    r_w1     <= 1'b0;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                    r_loaded <= 1'b1;
                    r_ready  <= 1'b1;
                    r_state  <= ST_IDLE;
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign load_ready_o     = r_ready;
    assign W1W0b_en_o       = r_en;
    assign b_o              = r_b;
    assign W0_o             = r_w0;
    assign W1_o             = r_w1;
    assign busy_o           = r_busy;
    assign done_o           = r_done;
    assign weights_loaded_o = r_loaded;

endmodule

// File: tb/tb_perceptron_wload.sv
// tb/tb_perceptron_wload.sv - directed scoreboard bench for perceptron_wload at WIDTH=8 and WIDTH=2
module tb_perceptron_wload;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       v8, rdy8, ab8;
    logic [7:0] bp8, w0p8, w1p8;
    logic [1:0] en8;
    logic       b8, w08, w18, busy8, done8, wl8;
    logic       v2, rdy2, ab2;
    logic [1:0] bp2, w0p2, w1p2;
    logic [1:0] en2;
    logic       b2, w02, w12, busy2, done2, wl2;

    perceptron_wload #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .load_valid_i(v8), .load_ready_o(rdy8),
        .b_par_i(bp8), .w0_par_i(w0p8), .w1_par_i(w1p8), .abort_i(ab8),
        .W1W0b_en_o(en8), .b_o(b8), .W0_o(w08), .W1_o(w18),
        .busy_o(busy8), .done_o(done8), .weights_loaded_o(wl8)
    );

    perceptron_wload #(.WIDTH(2)) u_dut2 (
        .clk(clk), .reset(reset), .load_valid_i(v2), .load_ready_o(rdy2),
        .b_par_i(bp2), .w0_par_i(w0p2), .w1_par_i(w1p2), .abort_i(ab2),
        .W1W0b_en_o(en2), .b_o(b2), .W0_o(w02), .W1_o(w12),
        .busy_o(busy2), .done_o(done2), .weights_loaded_o(wl2)
    );

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0] b;
        logic [7:0] w0;
        logic [7:0] w1;
        int         acc;
    } exp_t;

    exp_t       q8[$];
    exp_t       q2[$];
    logic [7:0] mb[2], mw0[2], mw1[2];
    int         c1[2], c2[2], c3[2];
    logic [1:0] prev[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model datapath shift registers plus scoreboard check at each done pulse.
    task automatic mon(input int k, input int w, input logic v, input logic rdy,
                       input logic [7:0] bp, input logic [7:0] w0p, input logic [7:0] w1p,
                       input logic [1:0] en, input logic sb, input logic s0, input logic s1,
                       input logic dn, input logic wl);
        exp_t       e;
        logic [7:0] m;
        bit         have;
        m = 8'((1 << w) - 1);
        chk($sformatf("unselected_lines_zero%0d", k),
            {29'd0, sb & (en != 2'b01), s0 & (en != 2'b10), s1 & (en != 2'b11)}, 32'd0);
        case (en)
            2'b01: begin mb[k]  = {mb[k][6:0], sb};  c1[k]++; end
            2'b10: begin mw0[k] = {mw0[k][6:0], s0}; c2[k]++; end
            2'b11: begin mw1[k] = {mw1[k][6:0], s1}; c3[k]++; end
            default: ;
        endcase
        if (en != 2'b00) begin
            chk($sformatf("code_order%0d", k), {31'd0, en >= prev[k]}, 32'd1);
            prev[k] = en;
        end
        if (dn) begin
            have = 0;
            if (k == 0 && q8.size() > 0) begin e = q8.pop_front(); have = 1; end
            if (k == 1 && q2.size() > 0) begin e = q2.pop_front(); have = 1; end
            chk($sformatf("done_expected%0d", k), {31'd0, have}, 32'd1);
            if (have) begin
                chk($sformatf("model_b%0d", k),  mb[k] & m,  e.b);
                chk($sformatf("model_w0_%0d", k), mw0[k] & m, e.w0);
                chk($sformatf("model_w1_%0d", k), mw1[k] & m, e.w1);
                chk($sformatf("cnt01_%0d", k), c1[k], w);
                chk($sformatf("cnt10_%0d", k), c2[k], w);
                chk($sformatf("cnt11_%0d", k), c3[k], w);
                chk($sformatf("done_latency%0d", k), cyc - e.acc, 3 * w + 1);
                chk($sformatf("loaded_at_done%0d", k), {31'd0, wl}, 32'd1);
            end
        end
        if (v && rdy) begin
            e.b = bp; e.w0 = w0p; e.w1 = w1p; e.acc = cyc + 1;
            if (k == 0) q8.push_back(e); else q2.push_back(e);
            mb[k] = 0; mw0[k] = 0; mw1[k] = 0;
            c1[k] = 0; c2[k] = 0; c3[k] = 0; prev[k] = 2'b00;
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            mon(0, 8, v8, rdy8, bp8, w0p8, w1p8, en8, b8, w08, w18, done8, wl8);
            mon(1, 2, v2, rdy2, {6'd0, bp2}, {6'd0, w0p2}, {6'd0, w1p2}, en2, b2, w02, w12, done2, wl2);
        end
    end

    task automatic wait_done(input int k, output int at);
        int n;
        n = 0;
        while (((k == 0) ? done8 : done2) !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk($sformatf("done_seen%0d", k), {31'd0, (k == 0) ? done8 : done2}, 32'd1);
        at = cyc;
    endtask

    initial begin
        int   a, a2, d, n;
        exp_t dummy;
        reset = 1'b0;
        v8 = 0; ab8 = 0; bp8 = 0; w0p8 = 0; w1p8 = 0;
        v2 = 0; ab2 = 0; bp2 = 0; w0p2 = 0; w1p2 = 0;
        for (int i = 0; i < 2; i++) begin
            mb[i] = 0; mw0[i] = 0; mw1[i] = 0; c1[i] = 0; c2[i] = 0; c3[i] = 0; prev[i] = 0;
        end

        #12;
        chk("rst_en", en8, 2'b00);
        chk("rst_lines", {b8, w08, w18}, 3'b000);
        chk("rst_busy", busy8, 1'b0);
        chk("rst_done", done8, 1'b0);
        chk("rst_loaded", wl8, 1'b0);
        chk("rst_en2", en2, 2'b00);
        @(posedge clk);
        #3 reset = 1'b1;
        tick();
        chk("rst_ready8", rdy8, 1'b1);
        chk("rst_ready2", rdy2, 1'b1);

        // Basic load 05/FD/7F
        bp8 = 8'h05; w0p8 = 8'hFD; w1p8 = 8'h7F; v8 = 1;
        tick();
        a = cyc; v8 = 0;
        chk("t1_ready_low", rdy8, 1'b0);
        chk("t1_en_first", en8, 2'b00);
        tick();
        chk("t1_en_b", en8, 2'b01);
        chk("t1_busy", busy8, 1'b1);
        chk("t1_b_msb", b8, 1'b0);
        wait_done(0, d);
        chk("t1_latency", d - a, 25);
        chk("t1_loaded", wl8, 1'b1);
        chk("t1_busy_off", busy8, 1'b0);
        tick();
        chk("t1_ready_back", rdy8, 1'b1);
        chk("t1_done_pulse", done8, 1'b0);

        // Back-to-back with valid held high
        bp8 = 8'h11; w0p8 = 8'h22; w1p8 = 8'h33; v8 = 1;
        tick();
        a = cyc;
        chk("b2b_acc1", rdy8, 1'b0);
        bp8 = 8'h44; w0p8 = 8'h55; w1p8 = 8'h66;
        n = 0;
        while (rdy8 !== 1'b1 && n < 100) begin tick(); n++; end
        chk("b2b_loaded_high", wl8, 1'b1);
        tick();
        a2 = cyc;
        chk("b2b_acc2", rdy8, 1'b0);
        chk("b2b_period", a2 - a, 26);
        chk("b2b_loaded_drop", wl8, 1'b0);
        v8 = 0;
        wait_done(0, d);
        tick();

        // Parallel inputs change mid-shift
        bp8 = 8'h5A; w0p8 = 8'h3C; w1p8 = 8'hC3; v8 = 1;
        tick();
        v8 = 0;
        repeat (5) tick();
        bp8 = 8'hAA; w0p8 = 8'hAA;
        repeat (12) tick();
        w1p8 = 8'hAA;
        wait_done(0, d);
        tick();

        // Abort in the third SH_W0 cycle
        bp8 = 8'h12; w0p8 = 8'h34; w1p8 = 8'h56; v8 = 1;
        tick();
        v8 = 0;
        repeat (10) tick();
        chk("ab_pre_en", en8, 2'b10);
        ab8 = 1;
        tick();
        ab8 = 0;
        chk("ab_en", en8, 2'b00);
        chk("ab_busy", busy8, 1'b0);
        chk("ab_done", done8, 1'b0);
        chk("ab_loaded", wl8, 1'b0);
        chk("ab_ready", rdy8, 1'b1);
        dummy = q8.pop_back();

        // Abort together with valid in IDLE: load still accepted
        bp8 = 8'h80; w0p8 = 8'h01; w1p8 = 8'hFF; v8 = 1; ab8 = 1;
        tick();
        v8 = 0; ab8 = 0;
        chk("abv_accepted", rdy8, 1'b0);
        wait_done(0, d);
        tick();

        // Asynchronous reset mid-SH_W1
        bp8 = 8'h00; w0p8 = 8'h00; w1p8 = 8'hFF; v8 = 1;
        tick();
        v8 = 0;
        repeat (19) tick();
        chk("rm_pre_en", en8, 2'b11);
        chk("rm_pre_w1", w18, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("rm_en", en8, 2'b00);
        chk("rm_lines", {b8, w08, w18}, 3'b000);
        chk("rm_busy", busy8, 1'b0);
        chk("rm_loaded", wl8, 1'b0);
        q8.delete();
        #3 reset = 1'b1;
        tick();
        chk("rm_ready", rdy8, 1'b1);
        chk("rm_en_after", en8, 2'b00);

        // WIDTH=2 instance
        bp2 = 2'b10; w0p2 = 2'b01; w1p2 = 2'b11; v2 = 1;
        tick();
        a = cyc; v2 = 0;
        tick();
        chk("w2_en_b", en2, 2'b01);
        chk("w2_b_msb", b2, 1'b1);
        chk("w2_busy", busy2, 1'b1);
        wait_done(1, d);
        chk("w2_latency", d - a, 7);
        tick();
        chk("w2_ready", rdy2, 1'b1);
        chk("q8_drained", q8.size(), 0);
        chk("q2_drained", q2.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/perceptron_wload.md
Name: perceptron_wload

Overview:
- Weight/bias loader that sits directly upstream of the perceptron datapath's serial weight shift registers.
- Accepts one parallel set {b, w0, w1} through a valid/ready handshake and serializes it MSB-first onto the 2-bit select code plus the three serial bit lines.
- Flags when the datapath holds a complete, coherent weight set, so the perceptron control block can gate inference on it.

Parameters:
WIDTH, 8, bit width of each of b, w0, w1 (two's complement); must be >= 2

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low reset
load_valid_i  input  1  parallel weight set offered
load_ready_o  output  1  loader idle and able to accept a set
b_par_i  input  WIDTH  bias word
w0_par_i  input  WIDTH  weight 0 word
w1_par_i  input  WIDTH  weight 1 word
abort_i  input  1  synchronous abort of an in-progress load
W1W0b_en_o  output  2  select code to datapath: 00 none, 01 b, 10 W0, 11 W1
b_o  output  1  serial bias bit
W0_o  output  1  serial weight-0 bit
W1_o  output  1  serial weight-1 bit
busy_o  output  1  serialization in progress
done_o  output  1  one-cycle pulse when a full set has been shifted
weights_loaded_o  output  1  sticky: datapath holds a complete set

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; W1W0b_en_o=00; b_o/W0_o/W1_o=0; busy_o=0; done_o=0; weights_loaded_o=0; load_ready_o=1 once reset deasserts. All outputs are registered.
- States: IDLE, SH_B, SH_W0, SH_W1, DONE. Bit counter cnt of width clog2(WIDTH), counting WIDTH-1 down to 0.
- IDLE:
  - load_ready_o=1.
  - Handshake at edge T when load_valid_i && load_ready_o: capture all three words into internal holding registers; cnt=WIDTH-1; go to SH_B; clear weights_loaded_o.
  - Inputs are ignored when no handshake occurs.
- SH_B: during the cycle following each edge, W1W0b_en_o=01 and b_o=b_hold[cnt]. Decrement cnt each cycle. At cnt==0, reload cnt=WIDTH-1 and go to SH_W0.
- SH_W0: W1W0b_en_o=10 and W0_o=w0_hold[cnt]. Transition to SH_W1 works the same way as SH_B.
- SH_W1: W1W0b_en_o=11 and W1_o=w1_hold[cnt]. At cnt==0, go to DONE.
- Serial lines not selected by the current code are driven 0. Because the datapath shifts left, inserting at the LSB, MSB-first delivery leaves each word correctly aligned after WIDTH shifts.
- Timing:
  - Handshake at edge T → codes valid from edge T+1 through edge T+3*WIDTH.
  - Exactly WIDTH cycles each of 01, 10, 11, contiguous, no gaps.
  - busy_o=1 during the same window; load_ready_o=0 from edge T until back in IDLE.
- DONE: lasts one cycle after edge T+3*WIDTH+1. W1W0b_en_o=00, done_o=1, weights_loaded_o set, then return to IDLE. The next handshake is possible at edge T+3*WIDTH+2. Total accept-to-accept period is 3*WIDTH+2 cycles.
- abort_i:
  - Sampled in SH_* states only. It takes priority over shifting.
  - On the next edge: state IDLE, W1W0b_en_o=00, serial lines 0, busy_o=0, no done_o pulse, weights_loaded_o stays 0 (the datapath is partially loaded).
  - abort_i in IDLE or DONE has no effect. abort_i together with load_valid_i in IDLE → the load is accepted.
- Holding registers are written only on handshake. Changes on the par inputs during shifting do not affect the stream.
- Reset mid-load: immediate return to reset values; weights_loaded_o=0.

Test Plan:
- WIDTH=8, reset released, offer b=0x05, w0=0xFD, w1=0x7F → codes 01×8, 10×8, 11×8. b_o stream 00000101, W0_o stream 11111101, W1_o stream 01111111. done_o pulses at accept+25. Model datapath registers read 0x05/0xFD/0x7F.
- load_valid_i held high continuously with two distinct sets → second accept occurs exactly 26 cycles after the first. Streams do not overlap; weights_loaded_o drops at the second accept and rises again at its done.
- Change b_par_i/w0_par_i to 0xAA mid-shift → stream still carries the originally captured values.
- abort_i asserted in the 3rd cycle of SH_W0 → next cycle code 00, busy_o=0, no done_o, weights_loaded_o=0; a new load is then accepted normally.
- Assert reset low asynchronously mid-SH_W1 (between clock edges) → outputs return to zero/00 immediately, before the next edge; load_ready_o=1 after release.
- WIDTH=2 instance, b=2'b10, w0=2'b01, w1=2'b11 → 6 shift cycles, done_o at accept+7, correct stream values.
